// File: rtl/acs_pm_unit.sv
// Add-compare-select stage with path-metric storage for an 8-state (K=4) Viterbi decoder.
// One trellis step per accepted cycle; metrics are renormalised when every MSB is set.
module acs_pm_unit #(
    parameter int unsigned PM_W      = 8,
    parameter int unsigned INIT_BIAS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_bm_valid,
    input  logic [31:0]         i_bm_in,
    output logic                o_dec_valid,
    output logic [7:0]          o_dec_out,
    output logic [8*PM_W-1:0]   o_pm_out,
    output logic [2:0]          o_best_state,
    output logic                o_norm_event
);

    localparam int unsigned N_ST = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                        r_state;
    logic [N_ST-1:0][PM_W-1:0]     r_pm;
    logic                          r_dec_valid;
    logic [N_ST-1:0]               r_dec_out;
    logic [2:0]                    r_best_state;
    logic                          r_norm_event;

    logic [N_ST-1:0][PM_W-1:0]     w_new;
    logic [N_ST-1:0][PM_W-1:0]     w_norm;
    logic [N_ST-1:0]               w_dec;
    logic [N_ST-1:0]               w_msb;
    logic                          w_all_msb;
    logic                          w_accept;
    logic [2:0]                    w_best;
    logic [PM_W-1:0]               w_min;

    // Predecessors of state n are {n[1:0],0} and {n[1:0],1}; ties resolve to p0
    for (genvar n = 0; n < 8; n++) begin : g_acs
        localparam int unsigned P0 = (n % 4) * 2;
        localparam int unsigned P1 = P0 + 1;
        logic [PM_W-1:0] w_c0;
        logic [PM_W-1:0] w_c1;
        assign w_c0     = r_pm[P0] + PM_W'(i_bm_in[4*n +: 2]);
        assign w_c1     = r_pm[P1] + PM_W'(i_bm_in[4*n+2 +: 2]);
        assign w_dec[n] = (w_c1 < w_c0);
        assign w_new[n] = w_dec[n] ? w_c1 : w_c0;
        assign w_msb[n] = w_new[n][PM_W-1];
    end

    assign w_all_msb = &w_msb;
    assign w_accept  = (r_state == ST_RUN) && i_bm_valid && !i_start;

    // Renormalise by clearing every MSB once all metrics have crossed half range
    always_comb begin
        w_norm = w_new;
        if (w_all_msb) begin
            for (int i = 0; i < 8; i++) begin
                w_norm[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Strict compare keeps the lowest index on equal minima
    always_comb begin
        w_best = 3'd0;
        w_min  = w_norm[0];
        for (int i = 1; i < 8; i++) begin
            if (w_norm[i] < w_min) begin
                w_min  = w_norm[i];
                w_best = 3'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_pm         <= '0;
            r_dec_valid  <= 1'b0;
            r_dec_out    <= '0;
            r_best_state <= 3'd0;
            r_norm_event <= 1'b0;
        end else if (i_start) begin
            r_state      <= ST_RUN;
            r_pm[0]      <= '0;
            for (int i = 1; i < 8; i++) begin
                r_pm[i] <= PM_W'(INIT_BIAS);
            end
            r_dec_valid  <= 1'b0;
            r_norm_event <= 1'b0;
        end else if (w_accept) begin
            r_pm         <= w_norm;
            r_dec_valid  <= 1'b1;
            r_dec_out    <= w_dec;
            r_best_state <= w_best;
            r_norm_event <= w_all_msb;
        end else begin
            r_dec_valid  <= 1'b0;
            r_norm_event <= 1'b0;
        end
    end

    assign o_dec_valid  = r_dec_valid;
    assign o_dec_out    = r_dec_out;
    assign o_pm_out     = r_pm;
    assign o_best_state = r_best_state;
    assign o_norm_event = r_norm_event;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Self-checking bench for acs_pm_unit: integer-arithmetic trellis model plus literal pins.
module tb_acs_pm_unit;

    localparam int unsigned PM_W      = 8;
    localparam int unsigned INIT_BIAS = 16;
    localparam int          MOD       = 1 << PM_W;
    localparam int          HALF      = 1 << (PM_W - 1);

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                bm_valid;
    logic [31:0]         bm_in;
    logic                dec_valid;
    logic [7:0]          dec_out;
    logic [8*PM_W-1:0]   pm_out;
    logic [2:0]          best_state;
    logic                norm_event;

    acs_pm_unit #(.PM_W(PM_W), .INIT_BIAS(INIT_BIAS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_bm_valid   (bm_valid),
        .i_bm_in      (bm_in),
        .o_dec_valid  (dec_valid),
        .o_dec_out    (dec_out),
        .o_pm_out     (pm_out),
        .o_best_state (best_state),
        .o_norm_event (norm_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int dv_cnt = 0;

    // Reference model: metrics as plain integers, trellis rules applied directly
    bit  m_run;
    int  m_pm [8];
    bit  m_dv;
    int  m_dec;
    int  m_best;
    bit  m_norm;

    always @(posedge clk or negedge rst_n) begin
        int c0, c1, nxt[8], lo;
        bit all_hi;
        if (!rst_n) begin
            m_run = 0; m_dv = 0; m_dec = 0; m_best = 0; m_norm = 0;
            for (int i = 0; i < 8; i++) m_pm[i] = 0;
        end else if (start) begin
            m_run = 1; m_dv = 0; m_norm = 0;
            m_pm[0] = 0;
            for (int i = 1; i < 8; i++) m_pm[i] = INIT_BIAS;
        end else if (m_run && bm_valid) begin
            m_dec  = 0;
            all_hi = 1;
            for (int n = 0; n < 8; n++) begin
                c0 = (m_pm[(n % 4) * 2]     + int'((bm_in >> (4*n))     & 3)) % MOD;
                c1 = (m_pm[(n % 4) * 2 + 1] + int'((bm_in >> (4*n + 2)) & 3)) % MOD;
                if (c1 < c0) begin
                    nxt[n] = c1;
                    m_dec  = m_dec + (1 << n);
                end else begin
                    nxt[n] = c0;
                end
                if (nxt[n] < HALF) all_hi = 0;
            end
            for (int n = 0; n < 8; n++) m_pm[n] = all_hi ? nxt[n] - HALF : nxt[n];
            lo = 0;
            for (int n = 7; n >= 0; n--) if (m_pm[n] <= m_pm[lo]) lo = n;
            m_best = lo;
            m_norm = all_hi;
            m_dv   = 1;
        end else begin
            m_dv   = 0;
            m_norm = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_pm();
        logic [63:0] v;
        v = '0;
        for (int n = 0; n < 8; n++) v[n*8 +: 8] = 8'(m_pm[n]);
        return v;
    endfunction

    // Advance one clock and compare every output against the model at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (dec_valid) dv_cnt++;
        chk("dec_valid",  64'(dec_valid),  64'(m_dv));
        chk("dec_out",    64'(dec_out),    64'(m_dec));
        chk("pm_out",     64'(pm_out),     model_pm());
        chk("best_state", 64'(best_state), 64'(m_best));
        chk("norm_event", 64'(norm_event), 64'(m_norm));
    endtask

    function automatic logic [31:0] rand_bm();
        logic [31:0] v;
        for (int f = 0; f < 16; f++) v[2*f +: 2] = 2'($urandom_range(0, 2));
        return v;
    endfunction

    localparam logic [63:0] PM_INIT  = 64'h1010_1010_1010_1000;
    localparam logic [63:0] PM_STEP0 = 64'h1010_1000_1010_1000;

    initial begin
        int          base;
        int          norm_step;
        logic [63:0] norm_pm;
        logic [7:0]  dec_or;

        rst_n = 1'b0; start = 1'b0; bm_valid = 1'b0; bm_in = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset_pm",   64'(pm_out), 64'h0);
        chk("reset_dv",   64'(dec_valid), 64'h0);
        chk("reset_best", 64'(best_state), 64'h0);

        // bm_valid while idle is ignored
        base = dv_cnt;
        bm_valid = 1'b1; bm_in = '0;
        repeat (3) tick();
        chk("idle_no_dv", 64'(dv_cnt - base), 64'd0);
        chk("idle_pm",    64'(pm_out), 64'h0);

        // start then a single zero-metric step
        bm_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_pm", 64'(pm_out), PM_INIT);
        bm_valid = 1'b1; bm_in = '0;
        tick();
        bm_valid = 1'b0;
        chk("step0_dv",   64'(dec_valid), 64'h1);
        chk("step0_pm",   64'(pm_out), PM_STEP0);
        chk("step0_dec",  64'(dec_out), 64'h0);
        chk("step0_best", 64'(best_state), 64'h0);
        tick();
        chk("step0_dv_off", 64'(dec_valid), 64'h0);

        // All branch metrics 2: converge, climb by 2, renormalise at step 64
        start = 1'b1; tick(); start = 1'b0;
        bm_valid = 1'b1; bm_in = 32'hAAAA_AAAA;
        norm_step = 0; norm_pm = '1; dec_or = '0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            dec_or |= dec_out;
            if (norm_event && norm_step == 0) begin
                norm_step = k;
                norm_pm   = 64'(pm_out);
            end
        end
        bm_valid = 1'b0;
        chk("norm_step", 64'(norm_step), 64'd64);
        chk("norm_pm",   norm_pm, 64'h0);
        chk("aa_dec",    64'(dec_or), 64'h0);

        // start and bm_valid together: start wins, sample dropped
        start = 1'b1; bm_valid = 1'b1; bm_in = rand_bm();
        tick();
        start = 1'b0; bm_valid = 1'b0;
        chk("start_wins_dv", 64'(dec_valid), 64'h0);
        chk("start_wins_pm", 64'(pm_out), PM_INIT);

        // Twelve back-to-back random steps
        base = dv_cnt;
        bm_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bm_in = rand_bm();
            tick();
        end
        bm_valid = 1'b0;
        tick();
        chk("burst12_dv", 64'(dv_cnt - base), 64'd12);

        // Reset in the middle of a burst clears outputs without a clock edge
        start = 1'b1; tick(); start = 1'b0;
        bm_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bm_in = rand_bm();
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pm",   64'(pm_out), 64'h0);
        chk("midrst_dv",   64'(dec_valid), 64'h0);
        chk("midrst_dec",  64'(dec_out), 64'h0);
        chk("midrst_best", 64'(best_state), 64'h0);
        chk("midrst_norm", 64'(norm_event), 64'h0);
        tick();
        rst_n = 1'b1;
        base = dv_cnt;
        for (int k = 0; k < 4; k++) begin
            bm_in = rand_bm();
            tick();
        end
        chk("post_rst_no_dv", 64'(dv_cnt - base), 64'd0);
        chk("post_rst_pm",    64'(pm_out), 64'h0);

        // Long random mix of starts, gaps and steps
        bm_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            start    = ($urandom_range(0, 39) == 0);
            bm_valid = ($urandom_range(0, 3) != 0);
            bm_in    = rand_bm();
            tick();
        end
        start = 1'b0; bm_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
